// File: rtl/palm_frame_sequencer.sv
// Frame-level controller for the palm identification stage: gates one gapless frame
// at a time into the stage, captures its results after a drain window, and hands them out.
module palm_frame_sequencer #(
    parameter int unsigned IMG_W     = 160,
    parameter int unsigned IMG_H     = 120,
    parameter int unsigned DRAIN_CYC = 3,
    parameter int unsigned MIN_WIDTH = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_valid,
    input  logic       pix_sof,
    input  logic       pix_data,
    output logic       pix_ready,
    input  logic       test_mode,
    input  logic [7:0] palm_height_test,
    output logic       id_rst,
    output logic       id_pixel,
    output logic       id_test,
    output logic [7:0] id_height_test,
    input  logic [7:0] id_start_r,
    input  logic [7:0] id_start_c,
    input  logic [7:0] id_end_r,
    input  logic [7:0] id_end_c,
    input  logic [7:0] id_width,
    input  logic [7:0] id_height,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_found,
    output logic [7:0] res_start_r,
    output logic [7:0] res_start_c,
    output logic [7:0] res_end_r,
    output logic [7:0] res_end_c,
    output logic [7:0] res_width,
    output logic [7:0] res_height,
    output logic [7:0] res_frame,
    output logic [7:0] err_abort,
    output logic       ovf
);

    localparam int unsigned CNT_W     = 15;
    localparam int unsigned DRN_W     = 4;
    localparam int unsigned FRAME_PIX = IMG_W * IMG_H;

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(FRAME_PIX);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_CYC - 1);
    localparam logic [7:0]       WIDTH_MIN  = 8'(MIN_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] pix_cnt;
    logic [DRN_W-1:0] drain_cnt;
    logic [7:0]       frame_cnt;
    logic             accept;
    logic [CNT_W-1:0] pix_cnt_inc;

    assign accept      = pix_valid & pix_ready;
    assign pix_cnt_inc = pix_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            pix_cnt        <= '0;
            drain_cnt      <= '0;
            frame_cnt      <= '0;
            pix_ready      <= 1'b0;
            id_rst         <= 1'b1;
            id_pixel       <= 1'b0;
            id_test        <= 1'b0;
            id_height_test <= '0;
            res_valid      <= 1'b0;
            res_found      <= 1'b0;
            res_start_r    <= '0;
            res_start_c    <= '0;
            res_end_r      <= '0;
            res_end_c      <= '0;
            res_width      <= '0;
            res_height     <= '0;
            res_frame      <= '0;
            err_abort      <= '0;
            ovf            <= 1'b0;
        end else begin
            id_pixel <= 1'b0;
            // Consumer handshake; a capture in the same cycle overrides below.
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    pix_ready <= 1'b1;
                    id_rst    <= 1'b1;
                    if (accept && pix_sof) begin
                        id_test        <= test_mode;
                        id_height_test <= palm_height_test;
                        id_pixel       <= pix_data;
                        id_rst         <= 1'b0;
                        pix_cnt        <= CNT_W'(1);
                        if (LAST_CNT == CNT_W'(1)) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                            pix_ready <= 1'b0;
                        end else begin
                            state <= S_STREAM;
                        end
                    end
                end

                S_STREAM: begin
                    // A gap or a premature sof aborts the frame without a result.
                    if (!pix_valid || pix_sof) begin
                        state  <= S_IDLE;
                        id_rst <= 1'b1;
                        if (err_abort != 8'hFF) begin
                            err_abort <= err_abort + 8'd1;
                        end
                    end else begin
                        id_pixel <= pix_data;
                        id_rst   <= 1'b0;
                        pix_cnt  <= pix_cnt_inc;
                        if (pix_cnt_inc == LAST_CNT) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                            pix_ready <= 1'b0;
                        end
                    end
                end

                S_DRAIN: begin
                    id_rst    <= 1'b0;
                    drain_cnt <= drain_cnt + DRN_W'(1);
                    if (drain_cnt == DRAIN_LAST) begin
                        state     <= S_IDLE;
                        id_rst    <= 1'b1;
                        pix_ready <= 1'b1;
                        frame_cnt <= frame_cnt + 8'd1;
                        // An unconsumed result wins over the new one.
                        if (res_valid && !res_ready) begin
                            ovf <= 1'b1;
                        end else begin
                            res_valid   <= 1'b1;
                            res_found   <= (id_width > WIDTH_MIN);
                            res_start_r <= id_start_r;
                            res_start_c <= id_start_c;
                            res_end_r   <= id_end_r;
                            res_end_c   <= id_end_c;
                            res_width   <= id_width;
                            res_height  <= id_height;
                            res_frame   <= frame_cnt + 8'd1;
                        end
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    pix_ready <= 1'b1;
                    id_rst    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_palm_frame_sequencer.sv
// Bench for palm_frame_sequencer: table of frame scenarios, hand-written corner sequences,
// and randomized frames checked against a transaction-level result model.
module tb_palm_frame_sequencer;

    localparam int unsigned IMG_W     = 12;
    localparam int unsigned IMG_H     = 6;
    localparam int unsigned DRAIN_CYC = 3;
    localparam int unsigned MIN_WIDTH = 17;
    localparam int          N         = IMG_W * IMG_H;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_valid, pix_sof, pix_data, pix_ready;
    logic       test_mode;
    logic [7:0] palm_height_test;
    logic       id_rst, id_pixel, id_test;
    logic [7:0] id_height_test;
    logic [7:0] stub_sr, stub_sc, stub_er, stub_ec, stub_w, stub_h;
    logic       res_valid, res_ready, res_found, ovf;
    logic [7:0] res_start_r, res_start_c, res_end_r, res_end_c, res_width, res_height;
    logic [7:0] res_frame, err_abort;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level expectations of the result interface.
    logic       exp_valid, exp_found, exp_ovf;
    logic [7:0] exp_sr, exp_sc, exp_er, exp_ec, exp_w, exp_h, exp_frame, exp_err, exp_fc;

    always #5 clk = ~clk;

    palm_frame_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .DRAIN_CYC(DRAIN_CYC), .MIN_WIDTH(MIN_WIDTH)
    ) dut (
        .clk(clk), .rst(rst),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data), .pix_ready(pix_ready),
        .test_mode(test_mode), .palm_height_test(palm_height_test),
        .id_rst(id_rst), .id_pixel(id_pixel), .id_test(id_test), .id_height_test(id_height_test),
        .id_start_r(stub_sr), .id_start_c(stub_sc), .id_end_r(stub_er), .id_end_c(stub_ec),
        .id_width(stub_w), .id_height(stub_h),
        .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
        .res_start_r(res_start_r), .res_start_c(res_start_c), .res_end_r(res_end_r),
        .res_end_c(res_end_c), .res_width(res_width), .res_height(res_height),
        .res_frame(res_frame), .err_abort(err_abort), .ovf(ovf)
    );

    typedef struct {
        bit         tm;
        logic [7:0] hs;
        logic [7:0] w, h, sr, sc, er, ec;
        int         abort_at;
        bit         abort_sof;
        bit         pop_before;
        bit         pop_cap;
        bit         e_valid;
        bit         e_found;
        logic [7:0] e_width;
        logic [7:0] e_frame;
        logic [7:0] e_err;
        bit         e_ovf;
    } vec_t;

    vec_t tbl[8];

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stub(input logic [7:0] w, h, sr, sc, er, ec);
        stub_w = w; stub_h = h; stub_sr = sr; stub_sc = sc; stub_er = er; stub_ec = ec;
    endtask

    task automatic model_reset();
        exp_valid = 0; exp_found = 0; exp_ovf = 0;
        exp_sr = 0; exp_sc = 0; exp_er = 0; exp_ec = 0; exp_w = 0; exp_h = 0;
        exp_frame = 0; exp_err = 0; exp_fc = 0;
    endtask

    task automatic model_capture(input bit pop_cap);
        exp_fc = exp_fc + 8'd1;
        if (exp_valid && !pop_cap) begin
            exp_ovf = 1;
        end else begin
            exp_valid = 1;
            exp_w = stub_w; exp_h = stub_h; exp_sr = stub_sr; exp_sc = stub_sc;
            exp_er = stub_er; exp_ec = stub_ec;
            exp_found = (int'(stub_w) > int'(MIN_WIDTH));
            exp_frame = exp_fc;
        end
    endtask

    task automatic check_results(input string tag);
        chk({tag, "/res_valid"}, res_valid, exp_valid);
        chk({tag, "/res_found"}, res_found, exp_found);
        chk({tag, "/res_width"}, res_width, exp_w);
        chk({tag, "/res_height"}, res_height, exp_h);
        chk({tag, "/res_start_r"}, res_start_r, exp_sr);
        chk({tag, "/res_start_c"}, res_start_c, exp_sc);
        chk({tag, "/res_end_r"}, res_end_r, exp_er);
        chk({tag, "/res_end_c"}, res_end_c, exp_ec);
        chk({tag, "/res_frame"}, res_frame, exp_frame);
        chk({tag, "/err_abort"}, err_abort, exp_err);
        chk({tag, "/ovf"}, ovf, exp_ovf);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "/id_rst"}, id_rst, 1);
        chk({tag, "/pix_ready"}, pix_ready, 0);
        chk({tag, "/id_pixel"}, id_pixel, 0);
        chk({tag, "/id_test"}, id_test, 0);
        chk({tag, "/id_height_test"}, id_height_test, 0);
        chk({tag, "/res_valid"}, res_valid, 0);
        chk({tag, "/res_found"}, res_found, 0);
        chk({tag, "/res_width"}, res_width, 0);
        chk({tag, "/res_height"}, res_height, 0);
        chk({tag, "/res_start_r"}, res_start_r, 0);
        chk({tag, "/res_end_c"}, res_end_c, 0);
        chk({tag, "/res_frame"}, res_frame, 0);
        chk({tag, "/err_abort"}, err_abort, 0);
        chk({tag, "/ovf"}, ovf, 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!pix_ready && n < 20) begin
            tick();
            n++;
        end
        chk("wait_ready", pix_ready, 1);
    endtask

    task automatic pop_result();
        res_ready = 1;
        tick();
        res_ready = 0;
        exp_valid = 0;
        chk("pop_valid_falls", res_valid, 0);
    endtask

    // Drive one frame (sof + N-1 pixels), optionally aborting at pixel index abort_at.
    task automatic feed_frame(input bit tm, input logic [7:0] hs, input int abort_at,
                              input bit abort_sof, input bit pop_cap);
        logic d;
        wait_ready();
        d = 1'($urandom);
        pix_valid = 1; pix_sof = 1; pix_data = d; test_mode = tm; palm_height_test = hs;
        tick();
        chk("sof_id_rst", id_rst, 0);
        chk("sof_pixel", id_pixel, d);
        chk("sof_id_test", id_test, tm);
        chk("sof_id_height", id_height_test, hs);
        test_mode = ~tm;
        palm_height_test = hs ^ 8'hA5;
        for (int k = 1; k < N; k++) begin
            if (k == abort_at) begin
                pix_valid = abort_sof; pix_sof = 1; pix_data = 1;
                tick();
                chk("abort_id_rst", id_rst, 1);
                chk("abort_pixel", id_pixel, 0);
                pix_valid = 0; pix_sof = 0;
                exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
                return;
            end
            d = 1'($urandom);
            pix_valid = 1; pix_sof = 0; pix_data = d;
            tick();
            chk("stream_pixel", id_pixel, d);
            chk("stream_id_rst", id_rst, 0);
            chk("stream_ready", pix_ready, (k < N - 1) ? 1 : 0);
        end
        pix_valid = 0; pix_data = 0;
        chk("frame_id_test", id_test, tm);
        chk("frame_id_height", id_height_test, hs);
        for (int j = 1; j <= int'(DRAIN_CYC); j++) begin
            chk("drain_ready", pix_ready, 0);
            chk("drain_id_rst", id_rst, 0);
            chk("drain_valid", res_valid, exp_valid);
            if (j >= 2) chk("drain_pixel", id_pixel, 0);
            if (j == int'(DRAIN_CYC) && pop_cap) res_ready = 1;
            tick();
        end
        res_ready = 0;
        model_capture(pop_cap);
        chk("cap_valid", res_valid, exp_valid);
        chk("cap_ready", pix_ready, 1);
        chk("cap_id_rst", id_rst, 1);
        chk("cap_pixel", id_pixel, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] w;
        int         gap, ab;
        rst = 1; pix_valid = 0; pix_sof = 0; pix_data = 0; res_ready = 0;
        test_mode = 0; palm_height_test = 0;
        set_stub(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 0;
        model_reset();

        //            tm  hs    w    h   sr  sc  er  ec  abort  asof popb popc  val fnd wid fr  err ovf
        tbl[0] = '{1, 8'd55,  29,  43, 40, 60, 82, 89, 0,     0,   0,   0,    1,  1,  29, 1,  0,  0};
        tbl[1] = '{0, 8'd9,    5,   5,  0,  0,  0,  0, 50,    0,   1,   0,    0,  1,  29, 1,  1,  0};
        tbl[2] = '{0, 8'd200, 17,  10,  1,  2,  3,  4, 0,     0,   0,   0,    1,  0,  17, 2,  1,  0};
        tbl[3] = '{1, 8'd1,   18,  11,  5,  6,  7,  8, 0,     0,   0,   0,    1,  0,  17, 2,  1,  1};
        tbl[4] = '{1, 8'd128, 200, 99,  9, 10, 11, 12, 0,     0,   0,   1,    1,  1, 200, 4,  1,  1};
        tbl[5] = '{0, 8'd0,    9,   9,  0,  0,  0,  0, 1,     1,   1,   0,    0,  1, 200, 4,  2,  1};
        tbl[6] = '{1, 8'd255, 255,  0, 13, 14, 15, 16, 0,     0,   0,   0,    1,  1, 255, 5,  2,  1};
        tbl[7] = '{0, 8'd77,   3,   3,  0,  0,  0,  0, N - 1, 0,   0,   0,    1,  1, 255, 5,  3,  1};

        for (int i = 0; i < 8; i++) begin
            set_stub(tbl[i].w, tbl[i].h, tbl[i].sr, tbl[i].sc, tbl[i].er, tbl[i].ec);
            if (tbl[i].pop_before) pop_result();
            feed_frame(tbl[i].tm, tbl[i].hs, tbl[i].abort_at, tbl[i].abort_sof, tbl[i].pop_cap);
            chk("vec_valid", res_valid, tbl[i].e_valid);
            chk("vec_found", res_found, tbl[i].e_found);
            chk("vec_width", res_width, tbl[i].e_width);
            chk("vec_frame", res_frame, tbl[i].e_frame);
            chk("vec_err_abort", err_abort, tbl[i].e_err);
            chk("vec_ovf", ovf, tbl[i].e_ovf);
        end
        pop_result();

        // Pixels without sof in IDLE are discarded and do not advance the frame.
        for (int i = 0; i < 10; i++) begin
            pix_valid = 1; pix_sof = 0; pix_data = 1;
            tick();
            chk("presof_id_rst", id_rst, 1);
            chk("presof_pixel", id_pixel, 0);
            chk("presof_ready", pix_ready, 1);
        end
        pix_valid = 0;
        set_stub(30, 20, 1, 1, 21, 31);
        feed_frame(1, 8'd42, 0, 0, 0);
        check_results("presof");

        // A sof that aborts must not start a frame; later non-sof pixels are ignored.
        pop_result();
        feed_frame(0, 8'd3, 5, 1, 0);
        for (int i = 0; i < N + 4; i++) begin
            pix_valid = 1; pix_sof = 0; pix_data = 1'($urandom);
            tick();
            chk("post_sof_abort_id_rst", id_rst, 1);
        end
        pix_valid = 0;
        check_results("sof_abort");

        // Abort counter saturates.
        repeat (260) feed_frame(0, 8'd0, 1, 0, 0);
        check_results("saturate");
        chk("err_saturated", err_abort, 255);

        // Reset in the middle of a frame.
        set_stub(40, 41, 42, 43, 44, 45);
        feed_frame(1, 8'd99, 0, 0, 0);
        wait_ready();
        pix_valid = 1; pix_sof = 1; pix_data = 1;
        tick();
        pix_sof = 0;
        for (int k = 1; k < 30; k++) begin
            pix_data = 1'($urandom);
            tick();
        end
        rst = 1;
        tick();
        check_reset_outputs("midrst");
        rst = 0; pix_valid = 0;
        model_reset();
        set_stub(29, 43, 40, 60, 40, 89);
        feed_frame(0, 8'd7, 0, 0, 0);
        check_results("post_rst");
        chk("post_rst_frame", res_frame, 1);

        // Randomized frames against the result model.
        for (int r = 0; r < 12; r++) begin
            w = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(10, 25)) : 8'($urandom);
            set_stub(w, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 2) == 0) pop_result();
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                pix_valid = 1'($urandom); pix_sof = 0; pix_data = 1'($urandom);
                tick();
                chk("rnd_idle_id_rst", id_rst, 1);
                chk("rnd_idle_pixel", id_pixel, 0);
            end
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N - 1) : 0;
            feed_frame(1'($urandom), 8'($urandom), ab, 1'($urandom),
                       ($urandom_range(0, 3) == 0));
            check_results("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
